// File: rtl/fetch_ctl.sv
// -----------------------------------------------------------------------------
// fetch_ctl
//   Front-end fetch controller. Owns the PC, issues in-order requests to
//   instruction memory, buffers returned instructions in a 2-entry FIFO for
//   decode, and handles redirects (taken branch / jump) from writeback by
//   reloading the PC, flushing the FIFO and discarding stale responses.
//
// Optional build macro:
//   FETCH_CTL_PERF_CNT_EN - adds redirect_cnt_o / drop_cnt_o event counters.
//
// Ports:
//   clk_i             clock, all state updates on the rising edge
//   reset_n_i         asynchronous active-low reset
//   stall_v_i         decode cannot accept an instruction this cycle
//   btaken_i          redirect request from writeback
//   btarget_i         redirect target (bits [1:0] ignored)
//   imem_req_v_o      fetch request valid
//   imem_req_addr_o   fetch address (current PC)
//   imem_req_ready_i  memory accepts the request
//   imem_resp_v_i     response valid (in request order)
//   imem_resp_data_i  response instruction word
//   instr_v_o         head instruction available to decode
//   instr_o           head instruction
//   instr_pc_o        PC of head instruction
//   flush_o           one-cycle pulse in the cycle after a redirect
//   redirect_cnt_o    (macro only) number of btaken_i cycles, wraps
//   drop_cnt_o        (macro only) number of discarded responses, wraps
//
// Handshake semantics: a request transfers on a rising edge where
// imem_req_v_o & imem_req_ready_i are both high; imem_req_v_o does not wait
// for ready, and the address is held stable until the transfer. Responses have
// no back-pressure: every response is consumed in the cycle it is valid,
// either into the FIFO or discarded. The decode side pops the head on an edge
// where instr_v_o & ~stall_v_i (and no redirect).
// -----------------------------------------------------------------------------
module fetch_ctl #(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   stall_v_i,
  input  logic                   btaken_i,
  input  logic [PC_WIDTH-1:0]    btarget_i,
  output logic                   imem_req_v_o,
  output logic [PC_WIDTH-1:0]    imem_req_addr_o,
  input  logic                   imem_req_ready_i,
  input  logic                   imem_resp_v_i,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data_i,
  output logic                   instr_v_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    instr_pc_o,
  output logic                   flush_o
`ifdef FETCH_CTL_PERF_CNT_EN
  ,
  output logic [31:0]            redirect_cnt_o,
  output logic [31:0]            drop_cnt_o
`endif
);

  // Architectural state
  logic [PC_WIDTH-1:0]    pc_q;
  logic [1:0]             outstanding_q;
  logic [1:0]             drop_q;
  logic                   flush_q;

  // Instruction FIFO: occupancy plus 1-bit wrapping pointers
  logic [1:0]             occ_q;
  logic                   rd_ptr_q;
  logic                   wr_ptr_q;
  logic [PC_WIDTH-1:0]    fifo_pc_q    [2];
  logic [INSTR_WIDTH-1:0] fifo_instr_q [2];

  // Tag queue: PC of each in-flight request, in request order
  logic [PC_WIDTH-1:0]    tag_q [2];
  logic                   tag_rd_q;
  logic                   tag_wr_q;

  // Datapath control
  logic [2:0]             reserved;
  logic                   hs;
  logic                   resp_ok;
  logic                   resp_drop;
  logic                   push;
  logic                   pop;
  logic [1:0]             outstanding_nxt;
  logic [PC_WIDTH-1:0]    target_aligned;

  // A request is only issued when a FIFO slot is guaranteed for its
  // response, counting both buffered and in-flight instructions.
  assign reserved        = {1'b0, outstanding_q} + {1'b0, occ_q};
  assign imem_req_v_o    = reset_n_i & ~btaken_i & (reserved < 3'd2);
  assign imem_req_addr_o = pc_q;
  assign hs              = imem_req_v_o & imem_req_ready_i;

  // Responses with nothing in flight are spurious and ignored entirely.
  assign resp_ok         = imem_resp_v_i & (outstanding_q != 2'd0);
  // A response in a redirect cycle is stale even when no drops are pending.
  assign resp_drop       = resp_ok & (btaken_i | (drop_q != 2'd0));
  assign push            = resp_ok & ~resp_drop;
  assign pop             = instr_v_o & ~stall_v_i & ~btaken_i;

  assign outstanding_nxt = outstanding_q + {1'b0, hs} - {1'b0, resp_ok};
  assign target_aligned  = btarget_i & ~PC_WIDTH'(3);

  assign instr_v_o       = (occ_q != 2'd0);
  assign instr_o         = instr_v_o ? fifo_instr_q[rd_ptr_q] : '0;
  assign instr_pc_o      = instr_v_o ? fifo_pc_q[rd_ptr_q]    : '0;
  assign flush_o         = flush_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      flush_q       <= 1'b0;
      occ_q         <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      tag_rd_q      <= 1'b0;
      tag_wr_q      <= 1'b0;
    end else begin
      flush_q       <= btaken_i;
      outstanding_q <= outstanding_nxt;
      // Tags leave the queue for dropped responses too, so the queue stays
      // aligned with the memory's response order across redirects.
      if (hs)      tag_wr_q <= ~tag_wr_q;
      if (resp_ok) tag_rd_q <= ~tag_rd_q;

      if (btaken_i) begin
        pc_q     <= target_aligned;
        // Everything still in flight after this edge belongs to the old path.
        drop_q   <= outstanding_nxt;
        occ_q    <= 2'd0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (hs)        pc_q   <= pc_q + PC_WIDTH'(4);
        if (resp_drop) drop_q <= drop_q - 2'd1;
        occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Storage arrays carry no reset; their contents are only observed through
  // the valid-gated outputs.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      tag_q[tag_wr_q] <= pc_q;
    end
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
      fifo_instr_q[wr_ptr_q] <= imem_resp_data_i;
    end
  end

`ifdef FETCH_CTL_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      redirect_cnt_o <= 32'd0;
      drop_cnt_o     <= 32'd0;
    end else begin
      if (btaken_i)  redirect_cnt_o <= redirect_cnt_o + 32'd1;
      if (resp_drop) drop_cnt_o     <= drop_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctl
//   Directed bench for fetch_ctl. A behavioural memory answers every accepted
//   request one cycle later (or holds responses when auto_resp is low). The
//   scoreboard queue exp_q holds the PCs decode must receive, in order; it is
//   cleared on every redirect because all older work is discarded.
// -----------------------------------------------------------------------------
module tb_fetch_ctl;

  logic        clk_i;
  logic        reset_n_i;
  logic        stall_v_i;
  logic        btaken_i;
  logic [31:0] btarget_i;
  logic        imem_req_v_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_resp_v_i;
  logic [31:0] imem_resp_data_i;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        flush_o;
`ifdef FETCH_CTL_PERF_CNT_EN
  logic [31:0] redirect_cnt_o;
  logic [31:0] drop_cnt_o;
`endif

  fetch_ctl dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .stall_v_i        (stall_v_i),
    .btaken_i         (btaken_i),
    .btarget_i        (btarget_i),
    .imem_req_v_o     (imem_req_v_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_resp_v_i    (imem_resp_v_i),
    .imem_resp_data_i (imem_resp_data_i),
    .instr_v_o        (instr_v_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .flush_o          (flush_o)
`ifdef FETCH_CTL_PERF_CNT_EN
    ,
    .redirect_cnt_o   (redirect_cnt_o),
    .drop_cnt_o       (drop_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- bench state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];      // PCs decode must still receive
  logic [31:0] mem_q[$];      // addresses accepted by memory, not yet answered
  logic [31:0] exp_addr;      // next expected request address
  bit          auto_resp;
  bit          prev_bt;
  int          flush_pulses;
  int          hs_200;
`ifdef FETCH_CTL_PERF_CNT_EN
  bit          resp_from_mem;
  int          pend_drops;
  int          drops_total;
  int          redirects;
  logic [31:0] d0;
`endif

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_v"},    imem_req_v_o,    32'd0);
    check({tag, "_req_addr"}, imem_req_addr_o, 32'd0);
    check({tag, "_instr_v"},  instr_v_o,       32'd0);
    check({tag, "_instr"},    instr_o,         32'd0);
    check({tag, "_instr_pc"}, instr_pc_o,      32'd0);
    check({tag, "_flush"},    flush_o,         32'd0);
  endtask

  // One clock cycle: observe at the falling edge, then apply next-cycle
  // memory response just after the rising edge.
  task automatic step();
    logic [31:0] p;
    @(negedge clk_i);
    check("flush", flush_o, prev_bt);
    if (flush_o) flush_pulses++;
    if (prev_bt) check("post_redirect_empty", instr_v_o, 1'b0);
    if (imem_req_v_o && imem_req_ready_i) begin
      check("req_addr", imem_req_addr_o, exp_addr);
      if (imem_req_addr_o[31:8] == 24'h2) hs_200++;
      mem_q.push_back(imem_req_addr_o);
      exp_q.push_back(exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
    if (instr_v_o && !stall_v_i && !btaken_i) begin
      check("pop_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        check("instr_pc", instr_pc_o, p);
        check("instr", instr_o, mem_data(p));
      end
    end
`ifdef FETCH_CTL_PERF_CNT_EN
    if (resp_from_mem && (btaken_i || pend_drops > 0)) begin
      drops_total++;
      if (!btaken_i) pend_drops--;
    end
    if (btaken_i) begin
      pend_drops = mem_q.size();
      redirects++;
    end
`endif
    if (btaken_i) begin
      exp_q.delete();
      exp_addr = btarget_i & 32'hFFFF_FFFC;
    end
    prev_bt = btaken_i;
    @(posedge clk_i);
    #1;
    btaken_i = 1'b0;
    if (auto_resp && mem_q.size() > 0) begin
      imem_resp_v_i    = 1'b1;
      imem_resp_data_i = mem_data(mem_q.pop_front());
`ifdef FETCH_CTL_PERF_CNT_EN
      resp_from_mem    = 1'b1;
`endif
    end else begin
      imem_resp_v_i    = 1'b0;
      imem_resp_data_i = 32'd0;
`ifdef FETCH_CTL_PERF_CNT_EN
      resp_from_mem    = 1'b0;
`endif
    end
  endtask

  // Let all in-flight responses return and decode empty the FIFO.
  task automatic drain();
    imem_req_ready_i = 1'b0;
    stall_v_i        = 1'b0;
    auto_resp        = 1'b1;
    repeat (6) step();
  endtask

  task automatic redirect(input logic [31:0] tgt);
    btaken_i  = 1'b1;
    btarget_i = tgt;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] late_addr;
    int          f0;
    reset_n_i        = 1'b0;
    stall_v_i        = 1'b0;
    btaken_i         = 1'b0;
    btarget_i        = 32'd0;
    imem_req_ready_i = 1'b0;
    imem_resp_v_i    = 1'b0;
    imem_resp_data_i = 32'd0;
    exp_addr         = 32'd0;
    auto_resp        = 1'b1;
    prev_bt          = 1'b0;
    flush_pulses     = 0;
    hs_200           = 0;
`ifdef FETCH_CTL_PERF_CNT_EN
    resp_from_mem    = 1'b0;
    pend_drops       = 0;
    drops_total      = 0;
    redirects        = 0;
`endif
    repeat (2) @(posedge clk_i);
    #1;
    check_idle_outputs("reset");

    // 1: free-running fetch from RESET_PC
    reset_n_i        = 1'b1;
    imem_req_ready_i = 1'b1;
    #1;
    check("t1_first_req_v", imem_req_v_o, 1'b1);
    check("t1_first_req_addr", imem_req_addr_o, 32'h0);
    step();
    #1;
    check("t1_no_instr_yet", instr_v_o, 1'b0);
    step();
    #1;
    check("t1_first_instr_v", instr_v_o, 1'b1);
    check("t1_first_instr_pc", instr_pc_o, 32'h0);
    repeat (8) step();

    // 2: decode stall fills the FIFO and throttles requests
    stall_v_i = 1'b1;
    repeat (6) step();
    #1;
    check("t2_full_valid", instr_v_o, 1'b1);
    check("t2_full_no_req", imem_req_v_o, 1'b0);
    check("t2_buffered", exp_q.size(), 32'd2);
    stall_v_i = 1'b0;
    repeat (6) step();

    // 3: two in flight (0x10, 0x14), redirect to 0x100
    drain();
    redirect(32'h10);
    step();
    imem_req_ready_i = 1'b1;
    auto_resp        = 1'b0;
    step();
    step();
    #1;
    check("t3_two_outstanding", imem_req_v_o, 1'b0);
    f0 = flush_pulses;
    redirect(32'h100);
    step();
    auto_resp = 1'b1;
    #1;
    check("t3_wait_drop_1", imem_req_v_o, 1'b0);
    step();
    #1;
    check("t3_wait_drop_2", imem_req_v_o, 1'b0);
    step();
    #1;
    check("t3_target_req_v", imem_req_v_o, 1'b1);
    check("t3_target_req_addr", imem_req_addr_o, 32'h100);
    step();
    step();
    #1;
    check("t3_first_instr_v", instr_v_o, 1'b1);
    check("t3_first_instr_pc", instr_pc_o, 32'h100);
    check("t3_one_flush", flush_pulses - f0, 32'd1);
    repeat (4) step();

    // 4: redirect coincides with a response, one more still in flight
    drain();
    imem_req_ready_i = 1'b1;
    auto_resp        = 1'b0;
    step();
    auto_resp = 1'b1;
    step();
`ifdef FETCH_CTL_PERF_CNT_EN
    d0 = drop_cnt_o;
`endif
    redirect(32'h42);
    #1;
    check("t4_resp_present", imem_resp_v_i, 1'b1);
    check("t4_req_blocked", imem_req_v_o, 1'b0);
    step();
    #1;
    check("t4_target_req_v", imem_req_v_o, 1'b1);
    check("t4_target_aligned", imem_req_addr_o, 32'h40);
    step();
`ifdef FETCH_CTL_PERF_CNT_EN
    #1;
    check("t4_drop_cnt_delta", drop_cnt_o - d0, 32'd2);
`endif
    repeat (4) step();

    // 5: back-to-back redirects, later target wins
    f0     = flush_pulses;
    hs_200 = 0;
    redirect(32'h200);
    step();
    redirect(32'h300);
    #1;
    check("t5_second_blocked", imem_req_v_o, 1'b0);
    step();
    repeat (10) step();
    check("t5_no_fetch_200", hs_200, 32'd0);
    check("t5_two_flushes", flush_pulses - f0, 32'd2);
`ifdef FETCH_CTL_PERF_CNT_EN
    check("redirect_cnt", redirect_cnt_o, redirects);
    check("drop_cnt", drop_cnt_o, drops_total);
`endif

    // 6: reset with two requests in flight, late responses ignored
    drain();
    imem_req_ready_i = 1'b1;
    auto_resp        = 1'b0;
    step();
    step();
    check("t6_two_in_flight", mem_q.size(), 32'd2);
    late_addr = mem_q[0];
    reset_n_i = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
`ifdef FETCH_CTL_PERF_CNT_EN
    check("t6_redirect_cnt_zero", redirect_cnt_o, 32'd0);
    check("t6_drop_cnt_zero", drop_cnt_o, 32'd0);
    pend_drops  = 0;
    drops_total = 0;
    redirects   = 0;
`endif
    mem_q.delete();
    exp_q.delete();
    exp_addr = 32'd0;
    prev_bt  = 1'b0;
    imem_resp_v_i    = 1'b1;
    imem_resp_data_i = mem_data(late_addr);
    step();
    imem_resp_v_i    = 1'b1;
    imem_resp_data_i = mem_data(late_addr + 32'd4);
    step();
    reset_n_i        = 1'b1;
    imem_resp_v_i    = 1'b1;
    imem_resp_data_i = mem_data(late_addr + 32'd4);
    auto_resp        = 1'b1;
    #1;
    check("t6_restart_req_v", imem_req_v_o, 1'b1);
    check("t6_restart_addr", imem_req_addr_o, 32'h0);
    step();
    step();
    #1;
    check("t6_first_instr_v", instr_v_o, 1'b1);
    check("t6_first_instr_pc", instr_pc_o, 32'h0);
    check("t6_first_instr", instr_o, mem_data(32'h0));
    repeat (6) step();

    drain();
    check("final_exp_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
